// File: rtl/pipe_hazard_ctrl.sv
// Hazard and sequencing controller for the 5-stage RV32I pipeline: shadow
// scoreboard of EX/MEM/WB, stage enables/flushes, EX forwarding, memory freeze.
module pipe_hazard_ctrl #(
  parameter int CNT_W = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [31:0]      id_instr,
  input  logic             id_valid,
  input  logic             ex_br_taken,
  input  logic             dmem_ack,
  output logic             dmem_req,
  output logic             pc_en,
  output logic             ifid_en,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             pipe_hold,
  output logic [1:0]       fwd_a,
  output logic [1:0]       fwd_b,
  output logic [CNT_W-1:0] stall_cnt,
  output logic [CNT_W-1:0] flush_cnt
);

  typedef struct packed {
    logic       valid;
    logic [4:0] rd;
    logic [4:0] rs1;
    logic [4:0] rs2;
    logic       regwrite;
    logic       is_load;
    logic       is_mem;
  } stage_t;

  // Unused source fields are stored as x0 so every later compare can treat
  // rs==0 as "no dependency".
  function automatic stage_t decode(input logic [31:0] instr);
    stage_t d;
    logic   use1;
    logic   use2;
    d       = '0;
    use1    = 1'b0;
    use2    = 1'b0;
    d.valid = 1'b1;
    d.rd    = instr[11:7];
    case (instr[6:0])
      7'b0110011: begin use1 = 1'b1; use2 = 1'b1; d.regwrite = 1'b1; end
      7'b0100011: begin use1 = 1'b1; use2 = 1'b1; d.is_mem = 1'b1; end
      7'b1100011: begin use1 = 1'b1; use2 = 1'b1; end
      7'b0010011: begin use1 = 1'b1; d.regwrite = 1'b1; end
      7'b0000011: begin
        use1       = 1'b1;
        d.regwrite = 1'b1;
        d.is_load  = 1'b1;
        d.is_mem   = 1'b1;
      end
      7'b1100111: begin use1 = 1'b1; d.regwrite = 1'b1; end
      7'b0110111, 7'b0010111, 7'b1101111: d.regwrite = 1'b1;
      default: d.regwrite = 1'b0;
    endcase
    d.rs1      = use1 ? instr[19:15] : 5'd0;
    d.rs2      = use2 ? instr[24:20] : 5'd0;
    d.regwrite = d.regwrite & (d.rd != 5'd0);
    return d;
  endfunction

  // MEM result wins over WB; a load in MEM has no data yet.
  function automatic logic [1:0] fwd_sel(input logic [4:0] rs, input stage_t ex,
                                         input stage_t mem, input stage_t wb);
    logic [1:0] sel;
    sel = 2'b00;
    if (!ex.valid || rs == 5'd0) begin
      sel = 2'b00;
    end else if (mem.valid && mem.regwrite && !mem.is_load && mem.rd == rs) begin
      sel = 2'b01;
    end else if (wb.valid && wb.regwrite && wb.rd == rs) begin
      sel = 2'b10;
    end else begin
      sel = 2'b00;
    end
    return sel;
  endfunction

  stage_t ex_r, mem_r, wb_r;
  stage_t id_dec_s;
  logic   req_s, mem_wait_s, flush_s, load_use_s;
  logic [CNT_W-1:0] stall_cnt_r, flush_cnt_r;

  assign id_dec_s   = decode(id_instr);
  assign req_s      = ~reset & mem_r.valid & mem_r.is_mem;
  assign mem_wait_s = req_s & ~dmem_ack;
  assign flush_s    = ~reset & ~mem_wait_s & ex_r.valid & ex_br_taken;
  assign load_use_s = ~reset & ~mem_wait_s & ~flush_s & id_valid &
                      ex_r.valid & ex_r.is_load & (ex_r.rd != 5'd0) &
                      ((id_dec_s.rs1 == ex_r.rd) | (id_dec_s.rs2 == ex_r.rd));

  // Stage control and forwarding, resolved in hazard priority order.
  always_comb begin
    dmem_req   = req_s;
    pc_en      = 1'b1;
    ifid_en    = 1'b1;
    ifid_flush = 1'b0;
    idex_flush = 1'b0;
    pipe_hold  = 1'b0;
    fwd_a      = 2'b00;
    fwd_b      = 2'b00;
    if (reset) begin
      pc_en      = 1'b0;
      ifid_en    = 1'b0;
      ifid_flush = 1'b1;
      idex_flush = 1'b1;
    end else begin
      fwd_a = fwd_sel(ex_r.rs1, ex_r, mem_r, wb_r);
      fwd_b = fwd_sel(ex_r.rs2, ex_r, mem_r, wb_r);
      if (mem_wait_s) begin
        pipe_hold = 1'b1;
        pc_en     = 1'b0;
        ifid_en   = 1'b0;
      end else if (flush_s) begin
        ifid_flush = 1'b1;
        idex_flush = 1'b1;
      end else if (load_use_s) begin
        pc_en      = 1'b0;
        ifid_en    = 1'b0;
        idex_flush = 1'b1;
      end else begin
        pc_en = 1'b1;
      end
    end
  end

  // Shadow scoreboard advances unless the memory stage is waiting.
  always_ff @(posedge clk) begin
    if (reset) begin
      ex_r  <= '0;
      mem_r <= '0;
      wb_r  <= '0;
    end else if (!mem_wait_s) begin
      wb_r  <= mem_r;
      mem_r <= ex_r;
      ex_r  <= (flush_s || load_use_s || !id_valid) ? '0 : id_dec_s;
    end
  end

  // Saturating performance counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      stall_cnt_r <= '0;
      flush_cnt_r <= '0;
    end else begin
      if ((mem_wait_s || load_use_s) && stall_cnt_r != {CNT_W{1'b1}}) begin
        stall_cnt_r <= stall_cnt_r + CNT_W'(1);
      end
      if (flush_s && flush_cnt_r != {CNT_W{1'b1}}) begin
        flush_cnt_r <= flush_cnt_r + CNT_W'(1);
      end
    end
  end

  assign stall_cnt = stall_cnt_r;
  assign flush_cnt = flush_cnt_r;

endmodule
